// File: rtl/spi_flash_rdid_responder_if.sv
// SPI pin bundle plus responder status, shared by the SPI master (or bench) and the RDID responder.
interface spi_flash_rdid_responder_if;
  logic       SPICLK;
  logic       SPIMOSI;
  logic       chip_select;
  logic       SPIMISO;
  logic       busy;
  logic       cmd_strobe;
  logic [7:0] last_cmd;
  logic [7:0] rdid_count;

  modport master (
    output SPICLK, SPIMOSI, chip_select,
    input  SPIMISO, busy, cmd_strobe, last_cmd, rdid_count
  );

  modport slave (
    input  SPICLK, SPIMOSI, chip_select,
    output SPIMISO, busy, cmd_strobe, last_cmd, rdid_count
  );
endinterface

// File: rtl/spi_flash_rdid_responder.sv
// SPI mode-0 slave standing in for a PROM: decodes one command byte, then streams the
// JEDEC RDID bytes or the status byte on SPIMISO. The SPI pins are oversampled on clk.
module spi_flash_rdid_responder #(
  parameter logic [7:0] MANUFACTURE_ID  = 8'h20,
  parameter logic [7:0] MEMORY_TYPE     = 8'h20,
  parameter logic [7:0] MEMORY_CAPACITY = 8'h15,
  parameter logic [7:0] STATUS_REG      = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset_n,
  spi_flash_rdid_responder_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_RDID   = 3'd2,
    ST_RDSR   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t     state_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] cs_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_idx_q;
  logic [1:0] byte_idx_d;
  logic [7:0] reload_d;
  logic       miso_q;
  logic       busy_q;
  logic       strobe_q;
  logic [7:0] last_cmd_q;
  logic [7:0] rdid_cnt_q;

  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_rise_s;
  logic       cs_fall_s;
  logic [7:0] cmd_next_s;

  // A select fall only counts once the synchronizer holds real pin samples that showed
  // the slave deselected; this keeps a reset released mid-transaction parked in IDLE.
  assign sclk_rise_s = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_s = ~sclk_q[1] & sclk_q[2];
  assign cs_rise_s   = cs_q[1] & ~cs_q[2];
  assign cs_fall_s   = armed_q & ~cs_q[1] & cs_q[2];
  assign cmd_next_s  = {shift_q[6:0], mosi_q[1]};

  // Pin synchronizers, edge-history flops and the deselect-seen qualifier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q  <= 3'b000;
      mosi_q  <= 2'b00;
      cs_q    <= 3'b111;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], bus.SPICLK};
      mosi_q  <= {mosi_q[0], bus.SPIMOSI};
      cs_q    <= {cs_q[1:0], bus.chip_select};
      fill_q  <= (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
      armed_q <= armed_q | ((fill_q == 2'd3) & cs_q[1]);
    end
  end

  // Next response byte: status repeats forever, the ID cycles through its three bytes.
  always_comb begin
    byte_idx_d = (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
    reload_d   = MANUFACTURE_ID;
    if (state_q == ST_RDSR) begin
      reload_d = STATUS_REG;
    end else begin
      case (byte_idx_d)
        2'd0:    reload_d = MANUFACTURE_ID;
        2'd1:    reload_d = MEMORY_TYPE;
        2'd2:    reload_d = MEMORY_CAPACITY;
        default: reload_d = MANUFACTURE_ID;
      endcase
    end
  end

  // Transaction state machine with registered pin and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      last_cmd_q <= 8'h00;
      rdid_cnt_q <= 8'h00;
    end else begin
      strobe_q <= 1'b0;
      busy_q   <= ~cs_q[1];
      if (cs_rise_s) begin
        state_q    <= ST_IDLE;
        shift_q    <= 8'h00;
        bit_cnt_q  <= 3'd0;
        byte_idx_q <= 2'd0;
        miso_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            state_q   <= cs_fall_s ? ST_CMD : ST_IDLE;
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              shift_q   <= cmd_next_s;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                last_cmd_q <= cmd_next_s;
                strobe_q   <= 1'b1;
                byte_idx_q <= 2'd0;
                case (cmd_next_s)
                  8'h9F: begin
                    state_q    <= ST_RDID;
                    shift_q    <= MANUFACTURE_ID;
                    rdid_cnt_q <= rdid_cnt_q + 8'd1;
                  end
                  8'h05: begin
                    state_q <= ST_RDSR;
                    shift_q <= STATUS_REG;
                  end
                  default: state_q <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_RDID, ST_RDSR: begin
            if (sclk_fall_s) begin
              miso_q    <= shift_q[7];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                shift_q    <= reload_d;
                byte_idx_q <= byte_idx_d;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          ST_IGNORE: miso_q <= 1'b0;
          default: begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.SPIMISO    = miso_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_strobe = strobe_q;
  assign bus.last_cmd   = last_cmd_q;
  assign bus.rdid_count = rdid_cnt_q;

endmodule

// File: tb/tb_spi_flash_rdid_responder.sv
// Directed bench: acts as a mode-0 SPI master and checks RDID, RDSR, ignore, abort and reset behaviour.
module tb_spi_flash_rdid_responder;
  localparam int HALF = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  spi_flash_rdid_responder_if bus ();

  spi_flash_rdid_responder #(
    .MANUFACTURE_ID (8'h20),
    .MEMORY_TYPE    (8'h20),
    .MEMORY_CAPACITY(8'h15),
    .STATUS_REG     (8'hA5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    bus.chip_select = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_high();
    wait_clks(6);
    bus.chip_select = 1'b1;
    wait_clks(8);
  endtask

  // Clocks nbits bits MSB first; strb_first is the negedge index after the last rise where cmd_strobe was first seen.
  task automatic spi_shift(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                           output int strb_first, output int strb_hits, output bit saw_hi);
    rx = 8'h00; strb_first = 0; strb_hits = 0; saw_hi = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.SPIMOSI = tx[i];
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (bus.SPIMISO) saw_hi = 1'b1;
        if (bus.cmd_strobe) strb_hits++;
      end
      rx[i] = bus.SPIMISO;
      bus.SPICLK = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (bus.SPIMISO) saw_hi = 1'b1;
        if (bus.cmd_strobe) begin
          strb_hits++;
          if (strb_first == 0 && i == 8 - nbits) strb_first = k;
        end
      end
      bus.SPICLK = 1'b0;
    end
  endtask

  task automatic read_bytes(input int n, input logic [7:0] exp0, input logic [7:0] exp1,
                            input logic [7:0] exp2, input string name);
    logic [7:0] rx;
    logic [7:0] exp;
    int f, h;
    bit s;
    for (int b = 0; b < n; b++) begin
      spi_shift(8'h00, 8, rx, f, h, s);
      exp = (b % 3 == 0) ? exp0 : ((b % 3 == 1) ? exp1 : exp2);
      checks++;
      if (rx !== exp) begin
        errors++;
        $display("FAIL %s byte%0d: got %h expected %h", name, b, rx, exp);
      end
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input string name);
    logic [7:0] rx;
    int f, h;
    bit s;
    spi_shift(cmd, 8, rx, f, h, s);
    checks++;
    if (h !== 1 || f < 3 || f > 4) begin
      errors++;
      $display("FAIL %s strobe: got hits=%0d at=%0d expected hits=1 at 3..4", name, h, f);
    end
    checks++;
    if (bus.last_cmd !== cmd) begin
      errors++;
      $display("FAIL %s last_cmd: got %h expected %h", name, bus.last_cmd, cmd);
    end
  endtask

  task automatic check_count(input logic [7:0] exp, input string name);
    checks++;
    if (bus.rdid_count !== exp) begin
      errors++;
      $display("FAIL %s rdid_count: got %0d expected %0d", name, bus.rdid_count, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clks(4);
    checks++;
    if ({bus.SPIMISO, bus.busy, bus.cmd_strobe} !== 3'b000 || bus.last_cmd !== 8'h00 || bus.rdid_count !== 8'h00) begin
      errors++;
      $display("FAIL reset: got miso=%b busy=%b strb=%b cmd=%h cnt=%h expected all 0",
               bus.SPIMISO, bus.busy, bus.cmd_strobe, bus.last_cmd, bus.rdid_count);
    end
    reset_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_rdid();
    cs_low();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rdid busy: got %b expected 1", bus.busy);
    end
    send_cmd(8'h9F, "rdid");
    check_count(8'd1, "rdid");
    read_bytes(3, 8'h20, 8'h20, 8'h15, "rdid");
    cs_high();
    checks++;
    if (bus.busy !== 1'b0 || bus.SPIMISO !== 1'b0) begin
      errors++;
      $display("FAIL rdid deselect: got busy=%b miso=%b expected 0 0", bus.busy, bus.SPIMISO);
    end
  endtask

  task automatic test_overrun();
    cs_low();
    send_cmd(8'h9F, "overrun");
    read_bytes(5, 8'h20, 8'h20, 8'h15, "overrun");
    cs_high();
    check_count(8'd2, "overrun");
  endtask

  task automatic test_rdsr();
    cs_low();
    send_cmd(8'h05, "rdsr");
    read_bytes(3, 8'hA5, 8'hA5, 8'hA5, "rdsr");
    cs_high();
    check_count(8'd2, "rdsr");
  endtask

  task automatic test_ignore();
    logic [7:0] rx0, rx1;
    int f, h;
    bit s0, s1;
    cs_low();
    send_cmd(8'h03, "ignore");
    spi_shift(8'hFF, 8, rx0, f, h, s0);
    spi_shift(8'hFF, 8, rx1, f, h, s1);
    cs_high();
    checks++;
    if (rx0 !== 8'h00 || rx1 !== 8'h00 || s0 !== 1'b0 || s1 !== 1'b0) begin
      errors++;
      $display("FAIL ignore miso: got %h %h seen_high=%b%b expected 00 00 00", rx0, rx1, s0, s1);
    end
    check_count(8'd2, "ignore");
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int f, h;
    bit s;
    cs_low();
    spi_shift(8'h9F, 5, rx, f, h, s);
    cs_high();
    checks++;
    if (h !== 0 || bus.last_cmd !== 8'h03) begin
      errors++;
      $display("FAIL abort partial: got hits=%0d cmd=%h expected 0 03", h, bus.last_cmd);
    end
    cs_low();
    send_cmd(8'h9F, "abort_rdid");
    read_bytes(3, 8'h20, 8'h20, 8'h15, "abort_rdid");
    cs_high();
    check_count(8'd3, "abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int f, h;
    bit s;
    cs_low();
    send_cmd(8'h9F, "mid");
    spi_shift(8'h00, 8, rx, f, h, s);
    spi_shift(8'h00, 4, rx, f, h, s);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.SPIMISO !== 1'b0 || bus.rdid_count !== 8'h00 || bus.last_cmd !== 8'h00 || bus.cmd_strobe !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got miso=%b cnt=%h cmd=%h strb=%b expected 0 00 00 0",
               bus.SPIMISO, bus.rdid_count, bus.last_cmd, bus.cmd_strobe);
    end
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(6);
    spi_shift(8'h9F, 8, rx, f, h, s);
    spi_shift(8'h00, 8, rx, f, h, s);
    checks++;
    if (h !== 0 || s !== 1'b0 || bus.last_cmd !== 8'h00) begin
      errors++;
      $display("FAIL mid no-reselect: got hits=%0d miso_high=%b cmd=%h expected 0 0 00", h, s, bus.last_cmd);
    end
    cs_high();
    cs_low();
    send_cmd(8'h9F, "mid_rdid");
    read_bytes(3, 8'h20, 8'h20, 8'h15, "mid_rdid");
    cs_high();
    check_count(8'd1, "mid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.SPICLK = 1'b0;
    bus.SPIMOSI = 1'b0;
    bus.chip_select = 1'b1;
    test_reset();
    test_rdid();
    test_overrun();
    test_rdsr();
    test_ignore();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_rdid_responder.md
# spi_flash_rdid_responder

SPI slave that models the responding end of the PROM identification transaction: it decodes the 8-bit command from the master and returns the JEDEC RDID bytes (manufacturer, memory type, capacity) or a status byte on SPIMISO. It is clocked by the divided system clock `clk` and oversamples the SPI pins. It is used as a bench and loopback partner for the SPI master, and as a stand-in PROM when the board flash is deselected.

## Interface
Parameters:
- MANUFACTURE_ID, 8'h20, first RDID response byte
- MEMORY_TYPE, 8'h20, second RDID response byte
- MEMORY_CAPACITY, 8'h15, third RDID response byte
- STATUS_REG, 8'h00, byte returned for RDSR (0x05)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- SPICLK  input  1  SPI clock from master, mode 0, asynchronous to clk
- SPIMOSI  input  1  master-out data, MSB first
- chip_select  input  1  active-low slave select
- SPIMISO  output  1  slave-out data, MSB first
- busy  output  1  high while chip_select is asserted (synchronized)
- cmd_strobe  output  1  one-clk pulse when the 8th command bit is captured
- last_cmd  output  8  most recently captured command byte
- rdid_count  output  8  number of completed RDID commands, wraps 255->0

## Operation
- Input conditioning: SPICLK, SPIMOSI and chip_select each pass through a 2-flop synchronizer. A third SPICLK flop provides rise and fall edge detection.
- State machine:
  - IDLE: SPIMISO=0, bit_cnt=0.
  - CMD: shift SPIMOSI in on each SPICLK rise. On the 8th rise, latch last_cmd, pulse cmd_strobe, and decode:
    - 0x9F -> RDID, and rdid_count increments.
    - 0x05 -> RDSR.
    - anything else -> IGNORE.
  - RDID: load MANUFACTURE_ID into the shift register at the 8th rise. Its bit7 drives SPIMISO on the following SPICLK fall. Each later fall shifts out the next bit. After 8 bits, load the next byte in the sequence MANUFACTURE_ID, MEMORY_TYPE, MEMORY_CAPACITY, then repeat from MANUFACTURE_ID.
  - RDSR: same shifting as RDID, but STATUS_REG is reloaded every 8 bits, indefinitely.
  - IGNORE: SPIMISO=0 and MOSI is discarded until deselect.
- Transitions:
  - IDLE->CMD on the synchronized chip_select fall.
  - Any state->IDLE on the synchronized chip_select rise. This clears bit_cnt, the byte index and the shift register, and forces SPIMISO=0 on the next clk. A partial command is discarded and cmd_strobe does not fire.
- SPICLK edges seen while chip_select is high are ignored.
- busy equals the synchronized, inverted chip_select.
- Width rules:
  - bit_cnt is 3 bits and wraps 7->0.
  - byte index is 2 bits, counts 0..2, and wraps to 0.
  - rdid_count is 8 bits, modulo 256.

## Timing
- Reset (reset_n low, takes effect immediately): state=IDLE, SPIMISO=0, busy=0, cmd_strobe=0, last_cmd=8'h00, rdid_count=8'h00, all counters 0.
- Reset deasserted mid-transaction: the block stays in IDLE until chip_select is seen high and then falls again.
- Pin-edge to internal-edge latency: 3 clk cycles.
- SPIMISO update: within 4 clk of the SPICLK fall at the pin.
- cmd_strobe: asserts 3-4 clk after the 8th SPICLK rise at the pin, for exactly 1 clk.
- last_cmd and rdid_count: update in the same cycle as cmd_strobe.
- Requirements on the master:
  - SPICLK high and low time each ≥6 clk.
  - chip_select fall to first SPICLK rise ≥4 clk.
  - Last SPICLK fall to chip_select rise ≥4 clk.
  - chip_select high time ≥4 clk.
- Simultaneous chip_select rise and SPICLK edge in the same synchronized cycle: deselect wins and the edge is dropped.

## Test plan
- RDID: send 0x9F, then clock 24 bits -> master captures 0x20, 0x20, 0x15; cmd_strobe fires once; last_cmd=0x9F; rdid_count=1.
- RDID overrun: send 0x9F plus 40 clocks -> bytes read 0x20, 0x20, 0x15, 0x20, 0x20.
- RDSR with STATUS_REG=8'hA5: send 0x05 plus 24 clocks -> 0xA5, 0xA5, 0xA5; rdid_count unchanged.
- Unknown command 0x03 plus 16 clocks -> SPIMISO stays 0 throughout; cmd_strobe fires; last_cmd=0x03.
- Abort: deselect after 5 command bits, then a full RDID -> no strobe for the partial command; RDID returns 0x20, 0x20, 0x15 from bit 0.
- Async reset pulse mid-RDID (after 12 response bits) -> SPIMISO=0, rdid_count=0, last_cmd=0x00 immediately. The next chip_select cycle with 0x9F returns the full ID sequence.
